// File: rtl/regfile_pkg.sv
// Shared constants and sequencer state encoding for the register-file port sequencer.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RF_IDX_W   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        IDLE,
        RD_RS1,
        RD_RS2,
        RESP
    } seq_state_t;
endpackage

// File: rtl/regfile_port_sequencer.sv
// Time-multiplexes rs1/rs2 operand reads and rd writes onto one register-file port.
// Optional RF_ZERO_SKIP_EN: x0 sources skip their read cycle and return 0.
module regfile_port_sequencer
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [REG_ADDR_W-1:0] reqRs1,
    input  logic [REG_ADDR_W-1:0] reqRs2,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [XLEN-1:0]       rs1Data,
    output logic [XLEN-1:0]       rs2Data,
    input  logic                  wbValid,
    output logic                  wbReady,
    input  logic [REG_ADDR_W-1:0] wbRd,
    input  logic [XLEN-1:0]       wbData,
    output logic [RF_IDX_W-1:0]   rfRegister,
    output logic                  rfWriteEnable,
    output logic [XLEN-1:0]       rfWriteData,
    input  logic [XLEN-1:0]       rfReadData
);
    seq_state_t            state;
    logic                  lastWasWrite;
    logic [REG_ADDR_W-1:0] rs1Q;
    logic [REG_ADDR_W-1:0] rs2Q;
    logic                  grantWrite;
    logic                  grantRead;

    // Write wins a tie only when the previous IDLE/RESP grant was not a write.
    always_comb begin
        grantWrite = 1'b0;
        grantRead  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (wbValid && (!reqValid || !lastWasWrite))
                        grantWrite = 1'b1;
                    else if (reqValid)
                        grantRead = 1'b1;
                end
                RESP:    grantWrite = wbValid;
                default: ;
            endcase
        end
    end

    always_comb begin
        wbReady       = grantWrite;
        reqReady      = grantRead;
        rfWriteEnable = grantWrite && (wbRd != REG_X0);
        rfWriteData   = grantWrite ? wbData : '0;
        rspValid      = !rst && (state == RESP);
        rfRegister    = '0;
        if (grantWrite)
            rfRegister = {{(RF_IDX_W-REG_ADDR_W){1'b0}}, wbRd};
        else if (!rst && state == RD_RS1)
            rfRegister = {{(RF_IDX_W-REG_ADDR_W){1'b0}}, rs1Q};
        else if (!rst && state == RD_RS2)
            rfRegister = {{(RF_IDX_W-REG_ADDR_W){1'b0}}, rs2Q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lastWasWrite <= 1'b0;
            rs1Q         <= '0;
            rs2Q         <= '0;
            rs1Data      <= '0;
            rs2Data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantWrite) begin
                        lastWasWrite <= 1'b1;
                    end else if (grantRead) begin
                        lastWasWrite <= 1'b0;
                        rs1Q         <= reqRs1;
                        rs2Q         <= reqRs2;
`ifdef RF_ZERO_SKIP_EN
                        if (reqRs1 == REG_X0) begin
                            rs1Data <= '0;
                            if (reqRs2 == REG_X0) begin
                                rs2Data <= '0;
                                state   <= RESP;
                            end else begin
                                state   <= RD_RS2;
                            end
                        end else begin
                            state <= RD_RS1;
                        end
`else
                        state <= RD_RS1;
`endif
                    end
                end
                RD_RS1: begin
                    rs1Data <= rfReadData;
`ifdef RF_ZERO_SKIP_EN
                    if (rs2Q == REG_X0) begin
                        rs2Data <= '0;
                        state   <= RESP;
                    end else begin
                        state   <= RD_RS2;
                    end
`else
                    state <= RD_RS2;
`endif
                end
                RD_RS2: begin
                    rs2Data <= rfReadData;
                    state   <= RESP;
                end
                RESP: begin
                    if (grantWrite)
                        lastWasWrite <= 1'b1;
                    if (rspReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Scoreboard bench for regfile_port_sequencer with a behavioural 32x32 register file.
module tb_regfile_port_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqReady, rspValid, rspReady;
    logic [4:0]  reqRs1, reqRs2, wbRd;
    logic [31:0] rs1Data, rs2Data, wbData, rfWriteData, rfReadData, rfRegister;
    logic        wbValid, wbReady, rfWriteEnable;

    logic [31:0] mem [32];
    int          cyc = 0;
    int          nCmp = 0;
    int          nBad = 0;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        int          due;
    } exp_t;
    exp_t sbQ[$];
    bit   latChecked = 0;

    regfile_port_sequencer dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqRs1(reqRs1), .reqRs2(reqRs2),
        .rspValid(rspValid), .rspReady(rspReady), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .wbValid(wbValid), .wbReady(wbReady), .wbRd(wbRd), .wbData(wbData),
        .rfRegister(rfRegister), .rfWriteEnable(rfWriteEnable),
        .rfWriteData(rfWriteData), .rfReadData(rfReadData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rfReadData = (rfRegister < 32) ? mem[rfRegister[4:0]] : 32'h0;
    always @(posedge clk) if (rfWriteEnable) mem[rfRegister[4:0]] <= rfWriteData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int expLat(input logic [4:0] a, input logic [4:0] b);
`ifdef RF_ZERO_SKIP_EN
        return 1 + int'(a != 0) + int'(b != 0);
`else
        return 3;
`endif
    endfunction

    // Response monitor: latency on first sight, operands on handshake.
    always @(negedge clk) begin
        if (!rst && rspValid) begin
            if (sbQ.size() == 0) begin
                check("unexpected_rsp", 32'(rspValid), 32'd0);
            end else begin
                if (!latChecked) begin
                    check("rsp_latency", 32'(cyc), 32'(sbQ[0].due));
                    latChecked = 1;
                end
                if (rspReady) begin
                    check("rs1Data", rs1Data, sbQ[0].e1);
                    check("rs2Data", rs2Data, sbQ[0].e2);
                    void'(sbQ.pop_front());
                    latChecked = 0;
                end
            end
        end
    end

    task automatic issueWrite(input logic [4:0] rd, input logic [31:0] d, input logic expEn);
        bit got = 0;
        wbValid = 1; wbRd = rd; wbData = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wbReady) begin
                got = 1;
                check("wr_enable", 32'(rfWriteEnable), 32'(expEn));
                check("wr_index", rfRegister, {27'd0, rd});
                check("wr_data", rfWriteData, d);
            end
            @(posedge clk); #1;
        end
        wbValid = 0;
        if (!got) check("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic issueRead(input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] e1, input logic [31:0] e2, input bit track);
        bit got = 0;
        reqValid = 1; reqRs1 = a; reqRs2 = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (reqReady) begin
                got = 1;
                if (track) sbQ.push_back('{e1, e2, cyc + expLat(a, b)});
            end
            @(posedge clk); #1;
        end
        reqValid = 0;
        if (!got) check("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrained();
        int i = 0;
        while (sbQ.size() != 0 && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        if (sbQ.size() != 0) check("drain_timeout", 32'(sbQ.size()), 32'd0);
    endtask

    bit expW [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    bit expR [8] = '{0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst = 1; rspReady = 1;
        wbValid = 1; wbRd = 5'd4; wbData = 32'hFFFF_FFFF;
        reqValid = 1; reqRs1 = 5'd1; reqRs2 = 5'd2;

        // Reset: every output low even with both requesters active.
        @(negedge clk);
        check("rst_wbReady", 32'(wbReady), 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd0);
        check("rst_wrEn", 32'(rfWriteEnable), 32'd0);
        check("rst_rfRegister", rfRegister, 32'd0);
        check("rst_rspValid", 32'(rspValid), 32'd0);
        @(posedge clk); #1;
        wbValid = 0; reqValid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_rs1Data", rs1Data, 32'd0);
        check("idle_rfRegister", rfRegister, 32'd0);
        @(posedge clk); #1;

        // x5 write then read with x0 as second source.
        issueWrite(5'd5, 32'hDEAD_BEEF, 1'b1);
        issueRead(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 1);
        waitDrained();

        // x0 write is accepted but discarded.
        issueWrite(5'd0, 32'h1234_5678, 1'b0);
        check("x0_mem", mem[0], 32'h0);
        issueRead(5'd0, 5'd0, 32'h0, 32'h0, 1);
        waitDrained();

        // rs1 == rs2.
        issueWrite(5'd3, 32'h0000_0033, 1'b1);
        issueRead(5'd3, 5'd3, 32'h33, 32'h33, 1);
        waitDrained();

        // Write during a stalled response must not disturb held operands.
        issueWrite(5'd7, 32'h0000_0011, 1'b1);
        rspReady = 0;
        issueRead(5'd7, 5'd5, 32'h11, 32'hDEAD_BEEF, 1);
        for (int i = 0; i < 10 && !rspValid; i++) begin
            @(posedge clk); #1;
        end
        check("stall_rspValid", 32'(rspValid), 32'd1);
        issueWrite(5'd7, 32'hA5A5_A5A5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_hold_valid", 32'(rspValid), 32'd1);
            check("stall_hold_rs1", rs1Data, 32'h11);
            @(posedge clk); #1;
        end
        rspReady = 1;
        waitDrained();
        issueRead(5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1);
        waitDrained();

        // Reset while in RD_RS2: the request vanishes.
        issueRead(5'd5, 5'd5, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("midrst_rspValid", 32'(rspValid), 32'd0);
        check("midrst_rs1Data", rs1Data, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        check("midrst_late_rspValid", 32'(rspValid), 32'd0);

        // Fairness from reset with both sides permanently requesting.
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        wbValid = 1; wbRd = 5'd9; wbData = 32'h0000_0099;
        reqValid = 1; reqRs1 = 5'd9; reqRs2 = 5'd9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("fair_w%0d", i), 32'(wbReady), 32'(expW[i]));
            check($sformatf("fair_r%0d", i), 32'(reqReady), 32'(expR[i]));
            if (reqReady) sbQ.push_back('{32'h99, 32'h99, cyc + expLat(5'd9, 5'd9)});
            @(posedge clk); #1;
        end
        wbValid = 0; reqValid = 0;
        waitDrained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
